// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage memory, redirect and decode handshake bundle
interface fetch_stage_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  // fetch stage side
  modport master (
    output imem_en, imem_addr, dec_valid, dec_inst, dec_pc,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  // memory / execute / decode side
  modport slave (
    input  imem_en, imem_addr, dec_valid, dec_inst, dec_pc,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, instruction memory reader and 2-entry decode buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst_n,
  fetch_stage_if.master bus
);

  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic        pending;
  logic        kill;
  logic [1:0]  count;
  logic [31:0] inst_q [2];
  logic [31:0] pc_q   [2];

  logic        flush;
  logic        head_valid;
  logic        deq;
  logic        issue;
  logic        push;
  logic [2:0]  occupancy;
  logic [31:0] target;

  // Issue, dequeue and head presentation; a redirect overrides everything in its cycle
  always_comb begin
    target        = bus.redirect_pc & 32'hFFFF_FFFC;
    flush         = rst_n & bus.redirect_valid;
    head_valid    = rst_n & (count != 2'd0) & ~bus.redirect_valid;
    deq           = head_valid & bus.dec_ready;
    // Slots already claimed once this cycle's dequeue leaves; keeps the FIFO from overflowing
    occupancy     = {1'b0, count} + {2'b00, pending} - {2'b00, deq};
    issue         = rst_n & (flush | (occupancy < 3'd2));
    // Responses arriving in a redirect cycle belong to the old path and are dropped here
    push          = rst_n & pending & ~kill & ~bus.redirect_valid;
    bus.imem_en   = issue;
    bus.imem_addr = flush ? target : fetch_pc;
    bus.dec_valid = head_valid;
    bus.dec_inst  = head_valid ? inst_q[0] : NOP_INST;
    bus.dec_pc    = head_valid ? pc_q[0] : 32'h0000_0000;
  end

  // PC, in-flight tracking and FIFO update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      pending    <= 1'b0;
      kill       <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      count      <= 2'd0;
      pending    <= 1'b1;
      pending_pc <= target;
      fetch_pc   <= target + 32'd4;
      kill       <= 1'b0;
    end else begin
      // Old-path data is discarded combinationally, so kill never has to outlive a cycle
      kill    <= 1'b0;
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end
      case ({push, deq})
        2'b10: begin
          inst_q[count[0]] <= bus.imem_rdata;
          pc_q[count[0]]   <= pending_pc;
          count            <= count + 2'd1;
        end
        2'b01: begin
          inst_q[0] <= inst_q[1];
          pc_q[0]   <= pc_q[1];
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            inst_q[0] <= bus.imem_rdata;
            pc_q[0]   <= pending_pc;
          end else begin
            inst_q[0] <= inst_q[1];
            pc_q[0]   <= pc_q[1];
            inst_q[1] <= bus.imem_rdata;
            pc_q[1]   <= pending_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
